// File: rtl/score_display.sv
// score_display: four-digit BCD pellet score with a ghost-free multiplexed active-low seven-segment driver
module score_display #(
  parameter int REFRESH_BITS = 18,
  parameter int GUARD        = 256,
  parameter int BLANK_LZ     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pellet_stb,
  input  logic        clear,
  output logic [15:0] score_bcd,
  output logic        sat,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int OW = REFRESH_BITS - 2;
  localparam logic [OW-1:0] GUARD_W = OW'(GUARD);
  logic [1:0]              rst_s;
  logic                    rst_i;
  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;
  logic [OW-1:0]           off;
  logic [15:0]             inc;
  logic                    cy;
  logic [3:0]              blank;
  logic [3:0]              digit;
  logic [3:0]              an_nxt;
  logic [6:0]              seg_nxt;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction
  assign rst_i = rst_s[1];
  assign sel   = cnt[REFRESH_BITS-1:REFRESH_BITS-2];
  assign off   = cnt[REFRESH_BITS-3:0];
  assign sat   = score_bcd == 16'h9999;
  assign dp    = 1'b1;
  assign digit = score_bcd[{sel, 2'b00} +: 4];
  // reset takes effect immediately but is released only on a clock edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_s <= 2'b00;
    else rst_s <= {rst_s[0], 1'b1};
  // BCD increment with ripple carry through all four digits
  always_comb begin
    inc = score_bcd;
    cy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inc[4*k +: 4] = cy ? (score_bcd[4*k +: 4] == 4'd9 ? 4'd0 : score_bcd[4*k +: 4] + 4'd1) : score_bcd[4*k +: 4];
      cy = cy & (score_bcd[4*k +: 4] == 4'd9);
    end
  end
  // score register: clear beats a strobe, saturated score holds
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) score_bcd <= '0;
    else if (clear) score_bcd <= '0;
    else if (pellet_stb && !sat) score_bcd <= inc;
  // free-running scan counter, wraps naturally
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else cnt <= cnt + 1'b1;
  // a digit is a leading zero when it and every higher digit are zero
  always_comb begin
    blank[3] = BLANK_LZ != 0 && score_bcd[15:12] == 4'd0;
    blank[2] = blank[3] && score_bcd[11:8] == 4'd0;
    blank[1] = blank[2] && score_bcd[7:4] == 4'd0;
    blank[0] = 1'b0;
  end
  // all anodes off during the guard window at the start of each slot
  always_comb begin
    an_nxt  = off < GUARD_W ? 4'b1111 : ~(4'b0001 << sel);
    seg_nxt = (off < GUARD_W || blank[sel]) ? 7'h7F : decode(digit);
  end
  // anodes and segments registered together so they switch on the same edge
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
endmodule
